// File: rtl/imem_loader.sv
// Byte-stream loader for the 256x16 instruction memory: assembles big-endian words and writes them sequentially.
// Optional trailing XOR checksum enabled with `define IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              load_active,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [15:0]       word_q, word_d;
  logic              hs;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign byte_ready = (state_q == S_COUNT) || (state_q == S_HI) ||
                      (state_q == S_LO)    || (state_q == S_CSUM);
  assign hs         = byte_valid & byte_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    word_d  = word_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_COUNT;
          addr_d  = BASE;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      S_COUNT: begin
        if (hs) begin
          // A zero count byte means a full memory image.
          rem_d = (ADDR_W+1)'(byte_in);
          if (byte_in == 8'h00) begin
            rem_d         = '0;
            rem_d[ADDR_W] = 1'b1;
          end
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (hs) begin
          word_d[15:8] = byte_in;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d       = csum_q ^ byte_in;
`endif
          state_d      = S_LO;
        end
      end
      S_LO: begin
        if (hs) begin
          word_d[7:0] = byte_in;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d      = csum_q ^ byte_in;
`endif
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q != (ADDR_W+1)'(1)) begin
          state_d = S_HI;
        end else begin
`ifdef IMEM_LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        if (hs) begin
          state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Reset also discards any half-assembled word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      rem_q   <= '0;
      word_q  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_we      = (state_q == S_WRITE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = word_q;
  assign load_active = (state_q == S_COUNT) || (state_q == S_HI) || (state_q == S_LO) ||
                       (state_q == S_WRITE) || (state_q == S_CSUM);
  assign done        = (state_q == S_DONE);
`ifdef IMEM_LOADER_CSUM_EN
  assign error       = (state_q == S_ERR);
`else
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0x00 and 0xFE) fed the same byte stream,
// checked against an expected-write queue per instance plus literal memory expectations.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;

  logic        byte_ready [2];
  logic        mem_we [2];
  logic [7:0]  mem_addr [2];
  logic [15:0] mem_wdata [2];
  logic        load_active [2];
  logic        done [2];
  logic        error [2];

  int tests = 0;
  int fails = 0;

  logic [23:0] q [2][$];
  logic [15:0] mem [2][256];
  int          we_cnt [2];
  bit          last_we [2];
  logic [15:0] wl [$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .load_active(load_active[0]), .done(done[0]), .error(error[0]));

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut1 (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .load_active(load_active[1]), .done(done[1]), .error(error[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write checker: every strobe must match the head of the expected queue.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!reset) begin
          last_we[k] = 1'b0;
        end else if (mem_we[k]) begin
          chk($sformatf("we%0d_ready_low", k), byte_ready[k], 0);
          chk($sformatf("we%0d_active", k), load_active[k], 1);
          if (q[k].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL wr%0d_unexpected: got write %0h@%0h expected none", k, mem_wdata[k], mem_addr[k]);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("wr%0d_addr", k), mem_addr[k], e[23:16]);
            chk($sformatf("wr%0d_data", k), mem_wdata[k], e[15:0]);
          end
          mem[k][mem_addr[k]] = mem_wdata[k];
          we_cnt[k]++;
          last_we[k] = 1'b1;
        end else begin
          if (last_we[k] && q[k].size() == 0) begin
`ifdef IMEM_LOADER_CSUM_EN
            chk($sformatf("csum_ready%0d", k), byte_ready[k], 1);
`else
            chk($sformatf("done_lat%0d", k), done[k], 1);
`endif
          end
          last_we[k] = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); byte_valid = 1'b0; byte_in = 8'($urandom);
      end
    end
    @(negedge clk); byte_in = b; byte_valid = 1'b1;
    while (!byte_ready[0] && g < 20) begin
      @(negedge clk); g++;
    end
    if (g >= 20) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got byte_ready=0 for 20 cycles expected 1");
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_in = 8'h5A;
  endtask

  task automatic run_frame(input logic [7:0] cnt, input bit bad, input bit gaps, input bit start_lo);
    int n = wl.size();
    int g = 0;
    logic [7:0] cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      q[0].push_back({8'(i), wl[i]});
      q[1].push_back({8'(254 + i), wl[i]});
      cs = cs ^ wl[i][15:8] ^ wl[i][7:0];
    end
    we_cnt[0] = 0;
    we_cnt[1] = 0;
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("active_after_start%0d", k), load_active[k], 1);
      chk($sformatf("done_clr%0d", k), done[k], 0);
      chk($sformatf("err_clr%0d", k), error[k], 0);
    end
    send_byte(cnt, gaps);
    for (int i = 0; i < n; i++) begin
      send_byte(wl[i][15:8], gaps);
      if (start_lo && i == 0) pulse_start();
      send_byte(wl[i][7:0], gaps);
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(cs ^ {7'b0, bad}, gaps);
`endif
    while (!(done[0] || error[0]) && g < 40) begin
      @(negedge clk); g++;
    end
    chk("finish_timeout", g < 40, 1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("done%0d", k), done[k], !bad);
      chk($sformatf("error%0d", k), error[k], bad);
      chk($sformatf("active_end%0d", k), load_active[k], 0);
      chk($sformatf("pending%0d", k), q[k].size(), 0);
      chk($sformatf("we_count%0d", k), we_cnt[k], n);
    end
  endtask

  task automatic chk_reset_vals();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready%0d", k), byte_ready[k], 0);
      chk($sformatf("rst_we%0d", k), mem_we[k], 0);
      chk($sformatf("rst_active%0d", k), load_active[k], 0);
      chk($sformatf("rst_done%0d", k), done[k], 0);
      chk($sformatf("rst_error%0d", k), error[k], 0);
      chk($sformatf("rst_addr%0d", k), mem_addr[k], (k == 0) ? 8'h00 : 8'hFE);
      chk($sformatf("rst_wdata%0d", k), mem_wdata[k], 16'h0000);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) mem[k][a] = 16'h0000;
      we_cnt[k] = 0;
    end
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;

    // Basic two-word frame; checksum byte would be 0x40.
    wl = '{16'h1234, 16'hABCD};
    run_frame(8'h02, 1'b0, 1'b0, 1'b0);
    chk("lit_mem0_00", mem[0][8'h00], 16'h1234);
    chk("lit_mem0_01", mem[0][8'h01], 16'hABCD);
    chk("lit_mem1_fe", mem[1][8'hFE], 16'h1234);
    chk("lit_mem1_ff", mem[1][8'hFF], 16'hABCD);

`ifdef IMEM_LOADER_CSUM_EN
    // Same frame with checksum 0x41.
    run_frame(8'h02, 1'b1, 1'b0, 1'b0);
    chk("lit_bad_mem0_01", mem[0][8'h01], 16'hABCD);
`endif

    // Three words with gapped byte_valid; base 0xFE instance wraps to 0x00.
    wl = '{16'h0F1E, 16'h2D3C, 16'h4B5A};
    run_frame(8'h03, 1'b0, 1'b1, 1'b0);
    chk("lit_gap_mem0_02", mem[0][8'h02], 16'h4B5A);
    chk("lit_wrap_mem1_00", mem[1][8'h00], 16'h4B5A);

    // Reset after the high byte of word 2.
    mem[0][8'h01] = 16'hDEAD;
    mem[1][8'hFF] = 16'hDEAD;
    q[0].push_back({8'h00, 16'hC0DE});
    q[1].push_back({8'hFE, 16'hC0DE});
    q[0].push_back({8'h01, 16'h7700});
    q[1].push_back({8'hFF, 16'h7700});
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'hC0, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'h77, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_vals();
    q[0].delete();
    q[1].delete();
    chk("lit_rst_mem0_00", mem[0][8'h00], 16'hC0DE);
    chk("lit_rst_mem0_01", mem[0][8'h01], 16'hDEAD);
    chk("lit_rst_mem1_fe", mem[1][8'hFE], 16'hC0DE);
    chk("lit_rst_mem1_ff", mem[1][8'hFF], 16'hDEAD);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Start pulsed while waiting for the low byte must be ignored.
    wl = '{16'h600D, 16'hF00D};
    run_frame(8'h02, 1'b0, 1'b0, 1'b1);
    chk("lit_lo_mem0_01", mem[0][8'h01], 16'hF00D);

    // Count byte 0: full 256-word image.
    wl.delete();
    for (int i = 0; i < 256; i++) wl.push_back({8'(i), ~8'(i)});
    run_frame(8'h00, 1'b0, 1'b0, 1'b0);
    chk("lit_full_mem0_ff", mem[0][8'hFF], 16'hFF00);
    chk("lit_full_mem0_00", mem[0][8'h00], 16'h00FF);
    chk("lit_full_mem1_fd", mem[1][8'hFD], 16'hFF00);
    chk("lit_full_addr0", mem_addr[0], 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
